vote_controller: RTL and testbench
==================================

Name: vote_controller

Overview:
- Session sequencer that sits directly upstream of the voter-ID checker and consumes its result.
- Latches a voter ID, issues a one-cycle check to the ID checker, and evaluates id_valid/id_used.
- Collects one candidate selection per valid voter, then pulses mark_done back to the checker.
- Maintains per-candidate and total vote tallies, and enforces a vote-entry timeout.

Parameters:
- NUM_CAND, 4, number of candidates (2..8); CAND_W = clog2(NUM_CAND), minimum 1.
- CW, 8, width of each tally counter and of total_votes.
- TIMEOUT, 1000, cycles allowed in VOTE before the session aborts (>=2).

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- voter_id  in  4  ID presented by the voter; sampled only on id_enter.
- id_enter  in  1  single-cycle request to start a session.
- cand_sel  in  CAND_W  candidate chosen; sampled only on vote_btn.
- vote_btn  in  1  single-cycle vote confirm.
- id_valid  in  1  from the ID checker, registered one cycle after check.
- id_used  in  1  from the ID checker, registered one cycle after check.
- chk_id  out  4  ID driven to the ID checker.
- check  out  1  one-cycle check request to the ID checker.
- mark_done  out  1  one-cycle request to mark chk_id as voted.
- busy  out  1  high whenever state != IDLE.
- vote_ok  out  1  one-cycle pulse when a vote is committed.
- rejected  out  1  one-cycle pulse when an ID is already used.
- timeout  out  1  one-cycle pulse when a VOTE session expires.
- proto_err  out  1  one-cycle pulse when the checker returns neither or both flags.
- tally  out  NUM_CAND*CW  per-candidate counts; candidate k at [k*CW +: CW].
- total_votes  out  CW  total committed votes.

Behaviour:
- Reset: state = IDLE; chk_id = 0; all tallies and total_votes = 0; every pulse output = 0; timer = 0. Reset is taken from any state and drops the session mid-operation with no mark_done. The ID checker shares the same reset.
- Outputs are registered or Moore-decoded from state. check is high exactly in CHECK; mark_done is high exactly in COMMIT.
- IDLE: on id_enter, latch chk_id <= voter_id and go to CHECK. id_enter is ignored in every other state.
- CHECK (1 cycle): check = 1; go to WAIT_RES.
- WAIT_RES (1 cycle): sample id_valid/id_used, which the checker presents this cycle.
  - valid=1, used=0: go to VOTE and clear the timer.
  - valid=0, used=1: go to REJECT.
  - neither flag, or both flags: go to IDLE and pulse proto_err.
- VOTE:
  - vote_btn with cand_sel < NUM_CAND: latch cand_sel and go to COMMIT.
  - vote_btn with cand_sel >= NUM_CAND: ignored; the timer keeps running.
  - The timer increments each cycle. When timer == TIMEOUT-1 with no accepted vote, go to IDLE, pulse timeout, no mark. A vote accepted in that same cycle wins over the timeout.
- COMMIT (1 cycle):
  - mark_done = 1.
  - tally[sel] increments and saturates at 2^CW-1.
  - total_votes increments and saturates at 2^CW-1.
  - Pulse vote_ok, then go to IDLE.
- REJECT (1 cycle): pulse rejected, no mark; go to IDLE.
- chk_id is held stable from CHECK through COMMIT.
- Latency: id_enter at cycle 0 gives check at cycle 1, the result at cycle 2, and VOTE from cycle 3. vote_btn at cycle n gives mark_done and vote_ok at cycle n+1, and busy low at n+2.
- Back-to-back sessions: id_enter is accepted in the first IDLE cycle after COMMIT, REJECT, timeout or proto_err.
- Tally bit fields for candidates >= NUM_CAND do not exist; the bus width is exactly NUM_CAND*CW.

Decomposition:
- Shared package vote_pkg holds:
  - the state enum (IDLE, CHECK, WAIT_RES, VOTE, COMMIT, REJECT);
  - ID_W = 4;
  - default NUM_CAND and CW.
- One sub-module, vote_tally: a NUM_CAND-way saturating counter bank plus the total counter, with an increment strobe and index input.

Test Plan:
- Fresh ID 3, cand_sel = 2 confirmed at VOTE cycle 5:
  - check at cycle 1, then VOTE;
  - mark_done and vote_ok at cycle 6 with chk_id = 3;
  - tally[2] = 1, total_votes = 1.
- ID 3 entered again after a committed vote: checker returns id_used, so rejected pulses at cycle 3, no mark_done, and tallies are unchanged.
- TIMEOUT = 10, valid ID, no vote_btn: timeout pulses 10 cycles after entering VOTE, with no mark_done and busy low on the next cycle.
- NUM_CAND = 3: vote_btn with cand_sel = 3 is ignored and the FSM stays in VOTE; a following cand_sel = 0 commits with tally[0] = 1.
- CW = 2: four votes for candidate 1 give tally[1] = 3 and total_votes = 3, with no wrap.
- Edge cases:
  - reset asserted in VOTE returns to IDLE with no mark_done, and tallies read 0 on the next cycle;
  - id_enter during busy is ignored;
  - checker returning both flags pulses proto_err.

Source files
------------

// File: rtl/vote_pkg.sv
// Shared types and defaults for the voting session sequencer.
package vote_pkg;

  localparam int ID_W         = 4;
  localparam int DEF_NUM_CAND = 4;
  localparam int DEF_CW       = 8;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WAIT_RES,
    VOTE,
    COMMIT,
    REJECT
  } state_e;

endpackage

// File: rtl/vote_tally.sv
// Bank of saturating per-candidate counters plus a saturating total counter.
module vote_tally
  import vote_pkg::*;
#(
  parameter int NUM_CAND = DEF_NUM_CAND,
  parameter int CW       = DEF_CW,
  parameter int IDX_W    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inc,
  input  logic [IDX_W-1:0]       idx,
  output logic [NUM_CAND*CW-1:0] tally,
  output logic [CW-1:0]          total
);

  logic [CW-1:0] total_q;
  logic [CW-1:0] total_d;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CAND; gi++) begin : g_cnt
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;

      // Bump this candidate's count when selected, holding at all-ones.
      always_comb begin
        cnt_d = cnt_q;
        if (inc && (idx == IDX_W'(gi)) && (cnt_q != {CW{1'b1}})) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Counter register, cleared by reset.
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign tally[gi*CW +: CW] = cnt_q;
    end
  endgenerate

  // Total of committed votes, saturating independently of the per-candidate counts.
  always_comb begin
    total_d = total_q;
    if (inc && (total_q != {CW{1'b1}})) begin
      total_d = total_q + 1'b1;
    end
  end

  // Total register, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      total_q <= '0;
    end else begin
      total_q <= total_d;
    end
  end

  assign total = total_q;

endmodule

// File: rtl/vote_controller.sv
// Voting session sequencer: ID check handshake, vote capture with timeout, tally update.
module vote_controller
  import vote_pkg::*;
#(
  parameter int NUM_CAND = DEF_NUM_CAND,
  parameter int CW       = DEF_CW,
  parameter int TIMEOUT  = 1000,
  localparam int CAND_W  = ($clog2(NUM_CAND) < 1) ? 1 : $clog2(NUM_CAND)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ID_W-1:0]        voter_id,
  input  logic                   id_enter,
  input  logic [CAND_W-1:0]      cand_sel,
  input  logic                   vote_btn,
  input  logic                   id_valid,
  input  logic                   id_used,
  output logic [ID_W-1:0]        chk_id,
  output logic                   check,
  output logic                   mark_done,
  output logic                   busy,
  output logic                   vote_ok,
  output logic                   rejected,
  output logic                   timeout,
  output logic                   proto_err,
  output logic [NUM_CAND*CW-1:0] tally,
  output logic [CW-1:0]          total_votes
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   chk_id_q, chk_id_d;
  logic [CAND_W-1:0] sel_q, sel_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              timeout_q, timeout_d;
  logic              proto_err_q, proto_err_d;

  // Next-state logic; the two abort pulses are registered alongside the return to IDLE.
  always_comb begin
    state_d     = state_q;
    chk_id_d    = chk_id_q;
    sel_d       = sel_q;
    timer_d     = timer_q;
    timeout_d   = 1'b0;
    proto_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (id_enter) begin
          chk_id_d = voter_id;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        state_d = WAIT_RES;
      end
      WAIT_RES: begin
        if (id_valid && !id_used) begin
          state_d = VOTE;
          timer_d = '0;
        end else if (!id_valid && id_used) begin
          state_d = REJECT;
        end else begin
          state_d     = IDLE;
          proto_err_d = 1'b1;
        end
      end
      VOTE: begin
        timer_d = timer_q + 1'b1;
        // An accepted vote on the last allowed cycle takes priority over expiry.
        if (vote_btn && (int'(cand_sel) < NUM_CAND)) begin
          sel_d   = cand_sel;
          state_d = COMMIT;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      COMMIT: begin
        state_d = IDLE;
      end
      REJECT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and session registers; reset abandons any session without marking.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      chk_id_q    <= '0;
      sel_q       <= '0;
      timer_q     <= '0;
      timeout_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      chk_id_q    <= chk_id_d;
      sel_q       <= sel_d;
      timer_q     <= timer_d;
      timeout_q   <= timeout_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign chk_id    = chk_id_q;
  assign check     = (state_q == CHECK);
  assign mark_done = (state_q == COMMIT);
  assign vote_ok   = (state_q == COMMIT);
  assign rejected  = (state_q == REJECT);
  assign busy      = (state_q != IDLE);
  assign timeout   = timeout_q;
  assign proto_err = proto_err_q;

  vote_tally #(
    .NUM_CAND (NUM_CAND),
    .CW       (CW),
    .IDX_W    (CAND_W)
  ) u_tally (
    .clk   (clk),
    .reset (reset),
    .inc   (state_q == COMMIT),
    .idx   (sel_q),
    .tally (tally),
    .total (total_votes)
  );

endmodule

// File: tb/tb_vote_controller.sv
// Scoreboard bench for vote_controller with an ID checker model and a session-level reference.
module tb_vote_controller;
  import vote_pkg::*;

  localparam int NC     = 3;
  localparam int CW     = 2;
  localparam int TO     = 10;
  localparam int CAND_W = 2;
  localparam int SAT    = (1 << CW) - 1;

  localparam int K_VOTE  = 0;
  localparam int K_REJ   = 1;
  localparam int K_TO    = 2;
  localparam int K_PROTO = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [3:0]        voter_id;
  logic              id_enter;
  logic [CAND_W-1:0] cand_sel;
  logic              vote_btn;
  logic              id_valid;
  logic              id_used;
  logic [3:0]        chk_id;
  logic              check;
  logic              mark_done;
  logic              busy;
  logic              vote_ok;
  logic              rejected;
  logic              timeout;
  logic              proto_err;
  logic [NC*CW-1:0]  tally;
  logic [CW-1:0]     total_votes;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int               kind;
    logic [3:0]       id;
    logic [NC*CW-1:0] tally;
    logic [CW-1:0]    total;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  exp_t pend_e;
  bit   pend_v = 1'b0;

  int  ref_tally[NC];
  int  ref_total = 0;
  bit  ref_used[16];
  bit  chk_used[16];
  bit  force_both = 1'b0;

  always #5 clk = ~clk;

  vote_controller #(
    .NUM_CAND (NC),
    .CW       (CW),
    .TIMEOUT  (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .voter_id    (voter_id),
    .id_enter    (id_enter),
    .cand_sel    (cand_sel),
    .vote_btn    (vote_btn),
    .id_valid    (id_valid),
    .id_used     (id_used),
    .chk_id      (chk_id),
    .check       (check),
    .mark_done   (mark_done),
    .busy        (busy),
    .vote_ok     (vote_ok),
    .rejected    (rejected),
    .timeout     (timeout),
    .proto_err   (proto_err),
    .tally       (tally),
    .total_votes (total_votes)
  );

  task automatic expect_eq(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NC*CW-1:0] ref_pack();
    logic [NC*CW-1:0] v;
    v = '0;
    for (int k = 0; k < NC; k++) v[k*CW +: CW] = CW'(ref_tally[k]);
    return v;
  endfunction

  function automatic bit registered(input logic [3:0] id);
    return (id >= 4'd1) && (id <= 4'd12);
  endfunction

  // ID checker model: registered flags one cycle after check, remembers marked IDs.
  always @(posedge clk) begin
    if (reset) begin
      id_valid <= 1'b0;
      id_used  <= 1'b0;
      for (int i = 0; i < 16; i++) chk_used[i] <= 1'b0;
    end else begin
      if (check) begin
        if (force_both) begin
          id_valid <= 1'b1;
          id_used  <= 1'b1;
        end else if (registered(chk_id)) begin
          id_valid <= !chk_used[chk_id];
          id_used  <= chk_used[chk_id];
        end else begin
          id_valid <= 1'b0;
          id_used  <= 1'b0;
        end
      end else begin
        id_valid <= 1'b0;
        id_used  <= 1'b0;
      end
      if (mark_done) chk_used[chk_id] <= 1'b1;
    end
  end

  // Monitor: pops an expectation on every outcome pulse, checks tallies the cycle after.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      if (pend_v) begin
        pend_v = 1'b0;
        expect_eq("tally_after", int'(tally), int'(pend_e.tally));
        expect_eq("total_after", int'(total_votes), int'(pend_e.total));
        if (pend_e.kind == K_VOTE || pend_e.kind == K_REJ)
          expect_eq("busy_after", int'(busy), 0);
      end
      if (vote_ok || rejected || timeout || proto_err) begin
        int act_kind;
        act_kind = vote_ok ? K_VOTE : rejected ? K_REJ : timeout ? K_TO : K_PROTO;
        expect_eq("one_pulse", int'(vote_ok) + int'(rejected) + int'(timeout) + int'(proto_err), 1);
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_event: got kind %0d expected no event at %0t", act_kind, $time);
        end else begin
          mon_e = expq.pop_front();
          $display("[TB] event kind=%0d expected=%0d id=%0d tally=%h total=%0d",
                   act_kind, mon_e.kind, chk_id, tally, total_votes);
          expect_eq("event_kind", act_kind, mon_e.kind);
          if (mon_e.kind == K_VOTE || mon_e.kind == K_REJ)
            expect_eq("event_chk_id", int'(chk_id), int'(mon_e.id));
          expect_eq("event_mark", int'(mark_done), (mon_e.kind == K_VOTE) ? 1 : 0);
          expect_eq("event_busy", int'(busy), (mon_e.kind == K_VOTE || mon_e.kind == K_REJ) ? 1 : 0);
          pend_e = mon_e;
          pend_v = 1'b1;
        end
      end else if (mark_done) begin
        expect_eq("stray_mark", int'(mark_done), 0);
      end
    end
  end

  // One voter session, started at a negedge in IDLE and returning at the first IDLE negedge.
  task automatic session(input logic [3:0] id, input int delay, input bit bad_first,
                         input logic [CAND_W-1:0] cand, input bit both, input bit busy_enter);
    int   kind;
    exp_t e;
    if (both || !registered(id))   kind = K_PROTO;
    else if (ref_used[id])         kind = K_REJ;
    else if (delay < TO)           kind = K_VOTE;
    else                           kind = K_TO;
    if (kind == K_VOTE) begin
      ref_used[id] = 1'b1;
      if (ref_tally[cand] < SAT) ref_tally[cand]++;
      if (ref_total < SAT) ref_total++;
    end
    e.kind  = kind;
    e.id    = id;
    e.tally = ref_pack();
    e.total = CW'(ref_total);
    expq.push_back(e);

    force_both = both;
    voter_id   = id;
    id_enter   = 1'b1;
    @(negedge clk);
    id_enter = 1'b0;
    voter_id = 4'($urandom);
    expect_eq("check_c1", int'(check), 1);
    expect_eq("chk_id_c1", int'(chk_id), int'(id));
    @(negedge clk);
    expect_eq("check_c2", int'(check), 0);
    force_both = 1'b0;
    if (kind == K_PROTO) begin
      @(negedge clk);
      return;
    end
    if (kind == K_REJ) begin
      @(negedge clk);
      @(negedge clk);
      return;
    end
    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      vote_btn = 1'b0;
      id_enter = 1'b0;
      cand_sel = CAND_W'($urandom);
      if (busy_enter && k == 1) begin
        id_enter = 1'b1;
        voter_id = id ^ 4'hF;
      end
      if (bad_first && k == delay - 1) begin
        vote_btn = 1'b1;
        cand_sel = 2'd3;
      end
      if (kind == K_VOTE && k == delay) begin
        vote_btn = 1'b1;
        cand_sel = cand;
        break;
      end
    end
    @(negedge clk);
    vote_btn = 1'b0;
    id_enter = 1'b0;
    if (kind == K_VOTE) @(negedge clk);
  endtask

  initial begin
    reset    = 1'b1;
    voter_id = '0;
    id_enter = 1'b0;
    cand_sel = '0;
    vote_btn = 1'b0;
    for (int k = 0; k < NC; k++) ref_tally[k] = 0;
    repeat (3) @(negedge clk);
    expect_eq("rst_busy", int'(busy), 0);
    expect_eq("rst_check", int'(check), 0);
    expect_eq("rst_mark", int'(mark_done), 0);
    expect_eq("rst_chk_id", int'(chk_id), 0);
    expect_eq("rst_tally", int'(tally), 0);
    expect_eq("rst_total", int'(total_votes), 0);
    expect_eq("rst_pulses", int'(vote_ok) + int'(rejected) + int'(timeout) + int'(proto_err), 0);
    reset = 1'b0;

    session(4'd3, 5, 1'b0, 2'd2, 1'b0, 1'b0);
    session(4'd3, 0, 1'b0, 2'd0, 1'b0, 1'b0);
    session(4'd5, TO, 1'b0, 2'd0, 1'b0, 1'b0);
    session(4'd6, 4, 1'b1, 2'd0, 1'b0, 1'b0);
    session(4'd7, TO - 1, 1'b0, 2'd1, 1'b0, 1'b1);
    session(4'd8, 2, 1'b0, 2'd1, 1'b0, 1'b0);
    session(4'd9, 0, 1'b0, 2'd1, 1'b0, 1'b0);
    session(4'd10, 3, 1'b0, 2'd1, 1'b0, 1'b0);
    session(4'd11, 1, 1'b0, 2'd0, 1'b1, 1'b0);
    session(4'd14, 1, 1'b0, 2'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    // Reset in the middle of a VOTE session.
    voter_id = 4'd12;
    id_enter = 1'b1;
    @(negedge clk);
    id_enter = 1'b0;
    repeat (3) @(negedge clk);
    expect_eq("pre_rst_busy", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    expect_eq("midrst_busy", int'(busy), 0);
    expect_eq("midrst_mark", int'(mark_done), 0);
    expect_eq("midrst_tally", int'(tally), 0);
    expect_eq("midrst_total", int'(total_votes), 0);
    reset = 1'b0;
    for (int k = 0; k < NC; k++) ref_tally[k] = 0;
    ref_total = 0;
    for (int i = 0; i < 16; i++) ref_used[i] = 1'b0;

    repeat (40) begin
      session(4'($urandom_range(0, 15)), int'($urandom_range(0, TO + 1)),
              1'($urandom_range(0, 1)), CAND_W'($urandom_range(0, NC - 1)),
              ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    expect_eq("queue_empty", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
